led_status_scan: RTL and testbench
==================================

Name: led_status_scan

Overview:
- Downstream of the multi-cycle controller.
- Consumes its debug nibbles (state, insn_type, insn_code, insn_stage) and time-multiplexes them onto a 4-digit 7-segment display, one hex digit each.
- Holds a prescaled scan counter, a per-frame input snapshot and a one-cycle inter-digit blanking slot that suppresses ghosting.
- All outputs are registered.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot; legal range 2..65535.
- ACTIVE_LOW, 1: 1 means an, seg and dp are active-low; 0 means they are active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- state  in  4  controller FSM state.
- insn_type  in  4  instruction type code.
- insn_code  in  4  instruction opcode code.
- insn_stage  in  4  pipeline stage code; only values 0..4 are used.
- an  out  4  digit enables; bit i selects digit i.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.

Behaviour:
- Reset: asynchronous and active-high, and may be applied mid-frame.
  - Clears div_cnt=0, idx=0, blank=0 and snap[3:0]=0. Also clears retire_cnt when the optional feature is compiled in.
  - Forces an, seg and dp to the off level: 4'b1111 / 7'h7F / 1 when ACTIVE_LOW=1, all zero otherwise.
  - Effect is immediate, with no clock required.
- Prescaler: div_cnt counts 0..SCAN_DIV-1. tick is true while div_cnt==SCAN_DIV-1.
- On an edge with tick:
  - div_cnt <= 0.
  - idx <= idx+1, 2-bit wrap 3 to 0.
  - blank <= 1.
  - If idx==3, snapshot at that edge: snap0<=state, snap1<=insn_stage, snap2<=insn_code, snap3<=insn_type.
- On an edge without tick: div_cnt <= div_cnt+1 and blank <= 0.
- Output register, updated every edge from the current blank, idx and snap:
  - If blank: an off, seg off, dp off.
  - Else: an one-hot on idx, seg = hex7(snap[idx]), dp off.
  - Output latency is 1 cycle.
- Digit timing:
  - Each digit is lit for SCAN_DIV-1 cycles, followed by exactly 1 blank cycle.
  - Frame length is 4*SCAN_DIV cycles.
- hex7, active-high {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - When ACTIVE_LOW=1, seg is the bitwise inversion of this code.
- Inputs may change at any cycle. The display changes only at the frame-wrap snapshot, so a digit never changes while lit.
- Before the first snapshot, all digits show "0".

Optional Feature:
- Macro: LED_SCAN_RETIRE_CNT_EN.
- Defined:
  - An 8-bit retire_cnt increments on each edge where insn_stage changes from nonzero to 3'b000. This is detected with a registered copy of insn_stage, which resets to 0.
  - retire_cnt wraps 255 to 0.
  - Digit 0 snapshots retire_cnt[3:0] instead of state.
  - dp is lit on digit 0 (not during blank) when snapped retire_cnt[4]==1.
- Undefined: no counter logic; digit 0 shows state and dp is always off.

Test Plan:
1. Reset and first digits (SCAN_DIV=4, ACTIVE_LOW=1):
   - Stimulus: release rst.
   - Required: 1 cycle later an=1110, seg=7'h40 ("0").
   - The 4th edge after release is a tick; the next cycle an=1111 (blank), then an=1101.
2. Snapshot timing:
   - Stimulus: hold state=4'h1, insn_stage=4'h2, insn_code=4'h3, insn_type=4'h1 through one full frame wrap.
   - Required: next frame shows digit0 seg=~06, digit1 ~5B, digit2 ~4F, digit3 ~06.
   - Changing the inputs mid-frame alters nothing until the next wrap.
3. Full hex coverage: feed state=4'hF, then 4'hA, on successive frames; digit 0 shows ~71, then ~77.
4. Async reset mid-frame:
   - Stimulus: assert rst while digit 2 is lit.
   - Required: an=1111 and seg=7F in the same cycle.
   - After release, scan restarts at digit 0 and snap is cleared.
5. ACTIVE_LOW=0: the scenario-1 sequence gives an=0001 with seg=3F, and blank cycles give an=0000.
6. With LED_SCAN_RETIRE_CNT_EN:
   - Stimulus: drive 17 insn_stage sequences 0,1,2,4,0.
   - Required: after the next wrap, digit 0 shows "1" (17 = 0x11) and dp is lit on digit 0.
   - Without the macro, dp stays off.

Source files
------------

// File: rtl/led_status_scan_if.sv
// Debug-nibble and display bus for led_status_scan.
// master: the side that drives the controller nibbles and watches the display.
// slave : the scanner, which consumes the nibbles and drives an/seg/dp.
interface led_status_scan_if;
    logic [3:0] state;
    logic [3:0] insn_type;
    logic [3:0] insn_code;
    logic [3:0] insn_stage;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output state, insn_type, insn_code, insn_stage,
        input  an, seg, dp
    );

    modport slave (
        input  state, insn_type, insn_code, insn_stage,
        output an, seg, dp
    );
endinterface

// File: rtl/led_status_scan.sv
// led_status_scan: time-multiplexes four controller debug nibbles onto a
// 4-digit 7-segment display. Digit 0 = state, 1 = insn_stage, 2 = insn_code,
// 3 = insn_type. Inputs are sampled once per frame (at the digit-3 to digit-0
// wrap), so a lit digit never changes. Each digit slot ends with a one-cycle
// blank to suppress ghosting. All display outputs are registered.
//
// Optional macro LED_SCAN_RETIRE_CNT_EN: counts retired instructions
// (insn_stage going nonzero -> 0), shows retire_cnt[3:0] on digit 0 and
// lights dp on digit 0 when the snapped retire_cnt[4] is set.
module led_status_scan #(
    parameter int SCAN_DIV   = 50000,  // clk cycles per digit slot, 2..65535
    parameter bit ACTIVE_LOW = 1'b1    // 1: an/seg/dp active-low
) (
    input  logic               clk,
    input  logic               rst,
    led_status_scan_if.slave   bus
);

    localparam logic [15:0] DIV_MAX  = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  AN_MASK  = {4{ACTIVE_LOW}};
    localparam logic [6:0]  SEG_MASK = {7{ACTIVE_LOW}};
    localparam logic        DP_OFF   = ACTIVE_LOW;

    // Active-high segment code {g,f,e,d,c,b,a} for one hex digit.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [15:0]      div_cnt_q, div_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             blank_q, blank_d;
    logic [3:0][3:0]  snap_q, snap_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             tick;
    logic [3:0]       digit0_src;

`ifdef LED_SCAN_RETIRE_CNT_EN
    logic [7:0]       retire_cnt_q, retire_cnt_d;
    logic [3:0]       stage_prev_q;
    logic             snap_dp_q, snap_dp_d;

    // Retire counter: one count per insn_stage transition from nonzero to zero.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if ((stage_prev_q != 4'd0) && (bus.insn_stage == 4'd0)) begin
            retire_cnt_d = retire_cnt_q + 8'd1;
        end
    end

    // Retire counter and previous-stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= 8'd0;
            stage_prev_q <= 4'd0;
            snap_dp_q    <= 1'b0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            stage_prev_q <= bus.insn_stage;
            snap_dp_q    <= snap_dp_d;
        end
    end

    assign digit0_src = retire_cnt_q[3:0];
`else
    assign digit0_src = bus.state;
`endif

    // Prescaler, digit index, blank slot and frame snapshot next-state.
    always_comb begin
        tick      = (div_cnt_q == DIV_MAX);
        div_cnt_d = div_cnt_q + 16'd1;
        idx_d     = idx_q;
        blank_d   = 1'b0;
        snap_d    = snap_q;
`ifdef LED_SCAN_RETIRE_CNT_EN
        snap_dp_d = snap_dp_q;
`endif
        if (tick) begin
            div_cnt_d = 16'd0;
            idx_d     = idx_q + 2'd1;
            blank_d   = 1'b1;
            if (idx_q == 2'd3) begin
                snap_d[0] = digit0_src;
                snap_d[1] = bus.insn_stage;
                snap_d[2] = bus.insn_code;
                snap_d[3] = bus.insn_type;
`ifdef LED_SCAN_RETIRE_CNT_EN
                snap_dp_d = retire_cnt_q[4];
`endif
            end
        end
    end

    // Display output next-state from the current blank, idx and snapshot.
    always_comb begin
        an_d  = AN_MASK;
        seg_d = SEG_MASK;
        dp_d  = DP_OFF;
        if (!blank_q) begin
            an_d  = (4'b0001 << idx_q) ^ AN_MASK;
            seg_d = hex7(snap_q[idx_q]) ^ SEG_MASK;
`ifdef LED_SCAN_RETIRE_CNT_EN
            if ((idx_q == 2'd0) && snap_dp_q) begin
                dp_d = ~DP_OFF;
            end
`endif
        end
    end

    // Scan state and registered display outputs; reset forces display off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= 16'd0;
            idx_q     <= 2'd0;
            blank_q   <= 1'b0;
            snap_q    <= '0;
            an_q      <= AN_MASK;
            seg_q     <= SEG_MASK;
            dp_q      <= DP_OFF;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            blank_q   <= blank_d;
            snap_q    <= snap_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_led_status_scan.sv
// Directed bench for led_status_scan with SCAN_DIV=4: one instance active-low,
// one active-high, both fed the same nibbles. Edge numbers in comments count
// rising edges after the most recent reset release.
module tb_led_status_scan;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    led_status_scan_if bus_l ();
    led_status_scan_if bus_h ();

    led_status_scan #(.SCAN_DIV(4), .ACTIVE_LOW(1'b1)) u_low (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    led_status_scan #(.SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u_high (
        .clk (clk),
        .rst (rst),
        .bus (bus_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic [3:0] st, input logic [3:0] stg,
                          input logic [3:0] code, input logic [3:0] typ);
        bus_l.state = st;  bus_l.insn_stage = stg;
        bus_l.insn_code = code; bus_l.insn_type = typ;
        bus_h.state = st;  bus_h.insn_stage = stg;
        bus_h.insn_code = code; bus_h.insn_type = typ;
    endtask

    task automatic set_stage(input logic [3:0] stg);
        bus_l.insn_stage = stg;
        bus_h.insn_stage = stg;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected values given in active-high form; the active-low instance
    // must show the bitwise inverse.
    task automatic chk2(input string tag, input logic [3:0] an_h,
                        input logic [6:0] seg_h, input logic dp_h);
        logic [11:0] obs_l, exp_l, obs_h, exp_h;
        obs_l = {bus_l.an, bus_l.seg, bus_l.dp};
        exp_l = {~an_h, ~seg_h, ~dp_h};
        obs_h = {bus_h.an, bus_h.seg, bus_h.dp};
        exp_h = {an_h, seg_h, dp_h};
        n_checks++;
        assert (obs_l === exp_l) else begin
            n_fail++;
            $error("FAIL %s_low: observed an/seg/dp=%h expected %h", tag, obs_l, exp_l);
        end
        n_checks++;
        assert (obs_h === exp_h) else begin
            n_fail++;
            $error("FAIL %s_high: observed an/seg/dp=%h expected %h", tag, obs_h, exp_h);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_dp;
        logic [6:0] exp_d0;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        set_in(4'h0, 4'h0, 4'h0, 4'h0);
        step(3);
        chk2("reset_off", 4'b0000, 7'h00, 1'b0);

        // Scenario 1: release and first digits
        @(negedge clk);
        rst = 1'b0;
        step(1);                                    // edge 1
        chk2("d0_first", 4'b0001, 7'h3F, 1'b0);
        step(3);                                    // edge 4 (tick)
        chk2("d0_at_tick", 4'b0001, 7'h3F, 1'b0);
        step(1);                                    // edge 5
        chk2("blank_after_d0", 4'b0000, 7'h00, 1'b0);
        step(1);                                    // edge 6
        chk2("d1_first", 4'b0010, 7'h3F, 1'b0);

        // Scenario 2: snapshot at edge 16, shown from edge 18
        set_in(4'h1, 4'h2, 4'h3, 4'h1);
        step(12);                                   // edge 18
        chk2("snap_d0", 4'b0001, 7'h06, 1'b0);
        set_in(4'hF, 4'h2, 4'h3, 4'h1);             // mid-frame change
        step(2);                                    // edge 20
        chk2("d0_held_while_lit", 4'b0001, 7'h06, 1'b0);
        step(2);                                    // edge 22
        chk2("snap_d1", 4'b0010, 7'h5B, 1'b0);
        step(4);                                    // edge 26
        chk2("snap_d2", 4'b0100, 7'h4F, 1'b0);
        step(3);                                    // edge 29
        chk2("blank_before_d3", 4'b0000, 7'h00, 1'b0);
        step(1);                                    // edge 30
        chk2("snap_d3", 4'b1000, 7'h06, 1'b0);

        // Scenario 3: F then A on digit 0
        step(4);                                    // edge 34
        chk2("hex_F", 4'b0001, 7'h71, 1'b0);
        set_in(4'hA, 4'h2, 4'h3, 4'h1);
        step(4);                                    // edge 38
        chk2("d1_after_F", 4'b0010, 7'h5B, 1'b0);
        step(12);                                   // edge 50
        chk2("hex_A", 4'b0001, 7'h77, 1'b0);

        // Scenario 4: async reset while digit 2 is lit
        step(8);                                    // edge 58
        chk2("d2_before_rst", 4'b0100, 7'h4F, 1'b0);
        #2;
        rst = 1'b1;
        set_stage(4'h0);
        #1;
        chk2("async_rst_immediate", 4'b0000, 7'h00, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1);                                    // edge 1'
        chk2("restart_d0", 4'b0001, 7'h3F, 1'b0);
        step(5);                                    // edge 6'
        chk2("restart_d1_cleared", 4'b0010, 7'h3F, 1'b0);

        // Scenario 6: 17 stage sequences 0,1,2,4,0 over edges 7'..91'
        for (int i = 0; i < 17; i++) begin
            set_stage(4'h0); step(1);
            set_stage(4'h1); step(1);
            set_stage(4'h2); step(1);
            set_stage(4'h4); step(1);
            set_stage(4'h0); step(1);
        end
        step(7);                                    // edge 98', snapshot at 96'
`ifdef LED_SCAN_RETIRE_CNT_EN
        exp_d0 = 7'h06;
        exp_dp = 1'b1;
`else
        exp_d0 = 7'h77;
        exp_dp = 1'b0;
`endif
        chk2("retire_d0", 4'b0001, exp_d0, exp_dp);
        step(3);                                    // edge 101'
        chk2("retire_blank_dp_off", 4'b0000, 7'h00, 1'b0);
        step(1);                                    // edge 102'
        chk2("retire_d1_dp_off", 4'b0010, 7'h3F, 1'b0);
        step(4);                                    // edge 106'
        chk2("retire_d2", 4'b0100, 7'h4F, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
